// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: the instruction-memory request/response side and
// the valid/ready hand-off to decode, plus fetch status outputs.
interface instr_fetch_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      mem_addr;
    logic             mem_hit;
    logic [31:0]      mem_q;
    logic             mem_clear;
    logic             mem_hold;
    logic             jump_valid;
    logic [31:0]      jump_addr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [31:0]      out_pc;
    logic             misalign;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        output mem_addr, mem_clear, mem_hold,
        input  mem_hit, mem_q,
        input  jump_valid, jump_addr,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        output misalign, fetch_cnt
    );

    modport slave (
        input  mem_addr, mem_clear, mem_hold,
        output mem_hit, mem_q,
        output jump_valid, jump_addr,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        input  misalign, fetch_cnt
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch-stage requester: owns the PC, waits for the instruction memory to
// return a word, and hands {instr, pc} to decode over valid/ready.
//
//  state | meaning
//  BOOT  | first cycle after reset, memory output cleared, hits ignored
//  FETCH | normal fetching, one word per hit when decode can take it
//  STALL | word pending in memory while decode holds a word, memory frozen
//  FLUSH | redirect in progress, memory output cleared, hits ignored
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, STALL, FLUSH} state_t;

    state_t           state, state_nx;
    logic [31:0]      pc, pc_nx;
    logic             out_valid, out_valid_nx;
    logic [31:0]      out_instr, out_instr_nx;
    logic [31:0]      out_pc, out_pc_nx;
    logic             misalign, misalign_nx;
    logic [CNT_W-1:0] fetch_cnt, fetch_cnt_nx;
    logic             xfer;

    // A redirect kills any handshake in the same cycle, so the transfer
    // condition excludes jump_valid.
    assign xfer = out_valid & bus.out_ready & ~bus.jump_valid;

    // Next-state and datapath updates; redirect overrides every state.
    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        out_valid_nx = out_valid;
        out_instr_nx = out_instr;
        out_pc_nx    = out_pc;
        misalign_nx  = misalign;
        fetch_cnt_nx = fetch_cnt;

        if (xfer) begin
            fetch_cnt_nx = fetch_cnt + CNT_W'(1);
        end

        if (bus.jump_valid) begin
            pc_nx        = bus.jump_addr & ~32'h3;
            out_valid_nx = 1'b0;
            state_nx     = FLUSH;
            if (bus.jump_addr[1:0] != 2'b00) begin
                misalign_nx = 1'b1;
            end
        end else begin
            case (state)
                BOOT: begin
                    state_nx = FETCH;
                end
                FETCH: begin
                    if (bus.mem_hit) begin
                        if (!out_valid || bus.out_ready) begin
                            out_instr_nx = bus.mem_q;
                            out_pc_nx    = pc;
                            out_valid_nx = 1'b1;
                            pc_nx        = pc + 32'd4;
                        end else begin
                            state_nx = STALL;
                        end
                    end else begin
                        out_valid_nx = out_valid & ~bus.out_ready;
                    end
                end
                STALL: begin
                    // Memory has been holding the word since we entered STALL.
                    if (bus.out_ready) begin
                        out_instr_nx = bus.mem_q;
                        out_pc_nx    = pc;
                        out_valid_nx = 1'b1;
                        pc_nx        = pc + 32'd4;
                        state_nx     = FETCH;
                    end
                end
                FLUSH: begin
                    out_valid_nx = 1'b0;
                    state_nx     = FETCH;
                end
                default: begin
                    state_nx = FETCH;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_pc    <= 32'h0;
            misalign  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            out_valid <= out_valid_nx;
            out_instr <= out_instr_nx;
            out_pc    <= out_pc_nx;
            misalign  <= misalign_nx;
            fetch_cnt <= fetch_cnt_nx;
        end
    end

    assign bus.mem_addr  = pc;
    assign bus.mem_clear = reset | (state == BOOT) | (state == FLUSH);
    assign bus.mem_hold  = (state == STALL) & ~bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_instr;
    assign bus.out_pc    = out_pc;
    assign bus.misalign  = misalign;
    assign bus.fetch_cnt = fetch_cnt;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. The memory model returns addr ^ KEY on a hit,
// so every delivered instruction can be matched against its PC.
module tb_instr_fetch;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    instr_fetch_if #(.CNT_W(4)) bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_q = bus.mem_hit ? (bus.mem_addr ^ KEY) : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.mem_hit = 1'b1; bus.out_ready = 1'b1;
        bus.jump_valid = 1'b0; bus.jump_addr = 32'h0;
        reset = 1'b1;
        tick(); tick();
        n_total++; if (bus.mem_clear !== 1'b1) $display("FAIL rst_clear got %b exp 1", bus.mem_clear); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.fetch_cnt !== 4'd0) $display("FAIL rst_cnt got %0d exp 0", bus.fetch_cnt); else n_pass++;
        n_total++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_pc got %h exp 0", bus.mem_addr); else n_pass++;
        n_total++; if (bus.misalign !== 1'b0) $display("FAIL rst_mis got %b exp 0", bus.misalign); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (bus.mem_clear !== 1'b1) $display("FAIL boot_clear got %b exp 1", bus.mem_clear); else n_pass++;
    endtask

    task automatic test_stream();
        tick();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL boot_hit_ignored got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.mem_clear !== 1'b0) $display("FAIL fetch_clear got %b exp 0", bus.mem_clear); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k) || bus.out_instr !== (32'(4 * k) ^ KEY)
                || bus.fetch_cnt !== 4'(k))
                $display("FAIL stream[%0d] got v=%b pc=%h ins=%h cnt=%0d exp v=1 pc=%h cnt=%0d",
                         k, bus.out_valid, bus.out_pc, bus.out_instr, bus.fetch_cnt, 32'(4 * k), k);
            else n_pass++;
        end
    endtask

    task automatic test_sparse();
        logic [31:0] exp_pc;
        logic [3:0]  exp_cnt;
        exp_pc = 32'd24; exp_cnt = 4'd6;
        bus.mem_hit = 1'b0;
        tick();
        n_total++; if (bus.out_valid !== 1'b0 || bus.fetch_cnt !== exp_cnt || bus.mem_addr !== exp_pc)
            $display("FAIL sparse_drain got v=%b cnt=%0d pc=%h exp v=0 cnt=%0d pc=%h", bus.out_valid, bus.fetch_cnt, bus.mem_addr, exp_cnt, exp_pc);
        else n_pass++;
        for (int r = 0; r < 3; r++) begin
            repeat (7) tick();
            n_total++; if (bus.out_valid !== 1'b0 || bus.mem_addr !== exp_pc)
                $display("FAIL sparse_idle[%0d] got v=%b pc=%h exp v=0 pc=%h", r, bus.out_valid, bus.mem_addr, exp_pc);
            else n_pass++;
            bus.mem_hit = 1'b1;
            tick();
            bus.mem_hit = 1'b0;
            n_total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== (exp_pc ^ KEY))
                $display("FAIL sparse_hit[%0d] got v=%b pc=%h ins=%h exp v=1 pc=%h", r, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc);
            else n_pass++;
            exp_pc = exp_pc + 32'd4;
            tick();
            exp_cnt = exp_cnt + 4'd1;
            n_total++; if (bus.out_valid !== 1'b0 || bus.fetch_cnt !== exp_cnt || bus.mem_addr !== exp_pc)
                $display("FAIL sparse_acc[%0d] got v=%b cnt=%0d pc=%h exp v=0 cnt=%0d pc=%h", r, bus.out_valid, bus.fetch_cnt, bus.mem_addr, exp_cnt, exp_pc);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        bus.mem_hit = 1'b1; bus.out_ready = 1'b0;
        tick();
        n_total++; if (bus.out_pc !== 32'd36 || bus.out_valid !== 1'b1 || bus.mem_hold !== 1'b0)
            $display("FAIL stall_load got pc=%h v=%b hold=%b exp pc=24 v=1 hold=0", bus.out_pc, bus.out_valid, bus.mem_hold);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (bus.mem_hold !== 1'b1 || bus.out_pc !== 32'd36 || bus.out_instr !== (32'd36 ^ KEY)
                || bus.mem_addr !== 32'd40 || bus.fetch_cnt !== 4'd9 || bus.out_valid !== 1'b1)
                $display("FAIL stall[%0d] got hold=%b pc=%h ins=%h addr=%h cnt=%0d exp hold=1 pc=24 addr=28 cnt=9",
                         i, bus.mem_hold, bus.out_pc, bus.out_instr, bus.mem_addr, bus.fetch_cnt);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        #1;
        n_total++; if (bus.mem_hold !== 1'b0) $display("FAIL stall_release_hold got %b exp 0", bus.mem_hold); else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd40 || bus.out_instr !== (32'd40 ^ KEY)
                       || bus.fetch_cnt !== 4'd10 || bus.mem_addr !== 32'd44)
            $display("FAIL stall_held_word got v=%b pc=%h cnt=%0d addr=%h exp v=1 pc=28 cnt=10 addr=2c",
                     bus.out_valid, bus.out_pc, bus.fetch_cnt, bus.mem_addr);
        else n_pass++;
        tick();
        n_total++; if (bus.out_pc !== 32'd44 || bus.fetch_cnt !== 4'd11)
            $display("FAIL stall_resume got pc=%h cnt=%0d exp pc=2c cnt=11", bus.out_pc, bus.fetch_cnt);
        else n_pass++;
    endtask

    task automatic test_jump();
        bus.jump_valid = 1'b1; bus.jump_addr = 32'h100;
        tick();
        bus.jump_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0 || bus.mem_clear !== 1'b1 || bus.mem_addr !== 32'h100
                       || bus.fetch_cnt !== 4'd11 || bus.misalign !== 1'b0)
            $display("FAIL jump_flush got v=%b clr=%b addr=%h cnt=%0d mis=%b exp v=0 clr=1 addr=100 cnt=11 mis=0",
                     bus.out_valid, bus.mem_clear, bus.mem_addr, bus.fetch_cnt, bus.misalign);
        else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b0 || bus.mem_clear !== 1'b0)
            $display("FAIL jump_after_flush got v=%b clr=%b exp v=0 clr=0", bus.out_valid, bus.mem_clear);
        else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_instr !== (32'h100 ^ KEY))
            $display("FAIL jump_target got v=%b pc=%h exp v=1 pc=100", bus.out_valid, bus.out_pc);
        else n_pass++;
        bus.jump_valid = 1'b1; bus.jump_addr = 32'h102;
        tick();
        bus.jump_addr = 32'h200;
        n_total++; if (bus.misalign !== 1'b1 || bus.mem_addr !== 32'h100 || bus.fetch_cnt !== 4'd11 || bus.out_valid !== 1'b0)
            $display("FAIL jump_misalign got mis=%b addr=%h cnt=%0d v=%b exp mis=1 addr=100 cnt=11 v=0",
                     bus.misalign, bus.mem_addr, bus.fetch_cnt, bus.out_valid);
        else n_pass++;
        tick();
        bus.jump_valid = 1'b0;
        n_total++; if (bus.mem_clear !== 1'b1 || bus.mem_addr !== 32'h200 || bus.misalign !== 1'b1)
            $display("FAIL jump_retarget got clr=%b addr=%h mis=%b exp clr=1 addr=200 mis=1", bus.mem_clear, bus.mem_addr, bus.misalign);
        else n_pass++;
        tick(); tick();
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.misalign !== 1'b1)
            $display("FAIL jump_retarget_fetch got v=%b pc=%h mis=%b exp v=1 pc=200 mis=1", bus.out_valid, bus.out_pc, bus.misalign);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bus.jump_valid = 1'b1; bus.jump_addr = 32'hFFFF_FFF8;
        tick();
        bus.jump_valid = 1'b0;
        tick(); tick();
        n_total++; if (bus.out_pc !== 32'hFFFF_FFF8 || bus.fetch_cnt !== 4'd11)
            $display("FAIL wrap_first got pc=%h cnt=%0d exp pc=fffffff8 cnt=11", bus.out_pc, bus.fetch_cnt);
        else n_pass++;
        tick();
        n_total++; if (bus.out_pc !== 32'hFFFF_FFFC || bus.mem_addr !== 32'h0 || bus.fetch_cnt !== 4'd12)
            $display("FAIL wrap_last got pc=%h addr=%h cnt=%0d exp pc=fffffffc addr=0 cnt=12", bus.out_pc, bus.mem_addr, bus.fetch_cnt);
        else n_pass++;
        tick();
        n_total++; if (bus.out_pc !== 32'h0 || bus.out_instr !== KEY || bus.mem_addr !== 32'h4 || bus.fetch_cnt !== 4'd13)
            $display("FAIL wrap_pc got pc=%h ins=%h addr=%h cnt=%0d exp pc=0 addr=4 cnt=13", bus.out_pc, bus.out_instr, bus.mem_addr, bus.fetch_cnt);
        else n_pass++;
        tick(); tick();
        n_total++; if (bus.fetch_cnt !== 4'd15) $display("FAIL cnt_max got %0d exp 15", bus.fetch_cnt); else n_pass++;
        tick();
        n_total++; if (bus.fetch_cnt !== 4'd0) $display("FAIL cnt_wrap got %0d exp 0", bus.fetch_cnt); else n_pass++;
    endtask

    task automatic test_reset_in_stall();
        bus.out_ready = 1'b0;
        tick();
        n_total++; if (bus.mem_hold !== 1'b1) $display("FAIL rs_enter_stall got hold=%b exp 1", bus.mem_hold); else n_pass++;
        reset = 1'b1;
        tick();
        n_total++; if (bus.out_valid !== 1'b0 || bus.fetch_cnt !== 4'd0 || bus.mem_addr !== 32'h0
                       || bus.misalign !== 1'b0 || bus.mem_hold !== 1'b0 || bus.mem_clear !== 1'b1)
            $display("FAIL rs_reset got v=%b cnt=%0d addr=%h mis=%b hold=%b clr=%b exp v=0 cnt=0 addr=0 mis=0 hold=0 clr=1",
                     bus.out_valid, bus.fetch_cnt, bus.mem_addr, bus.misalign, bus.mem_hold, bus.mem_clear);
        else n_pass++;
        reset = 1'b0; bus.out_ready = 1'b1;
        tick();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rs_boot got v=%b exp 0", bus.out_valid); else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.fetch_cnt !== 4'd0)
            $display("FAIL rs_refetch got v=%b pc=%h cnt=%0d exp v=1 pc=0 cnt=0", bus.out_valid, bus.out_pc, bus.fetch_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_sparse();
        test_stall();
        test_jump();
        test_wrap();
        test_reset_in_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
